// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator call scheduler.
// Holds the sweep FSM state encoding and the default floor geometry.
package elevator_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_FIRE = 2'd3
    } state_t;

    localparam int FLOOR_G              = 0;
    localparam int DEF_NUM_FLOORS       = 4;
    localparam int DEF_FLOOR_W          = 2;
    localparam int DEF_DEBOUNCE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES   = 64;

endpackage

// File: rtl/call_debounce.sv
// Debounce for one call button: 2-flop synchroniser, saturating run counter,
// single-cycle press pulse. Ports: clk, rst (async active-low), btn (raw), press.
module call_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != CW'(DEBOUNCE_CYCLES))
                cnt <= cnt + 1'b1;
        end
    end

    // Fires on the edge the counter reaches its limit; saturation stops repeats.
    assign press = sync2 && (cnt == CW'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: debounced calls, pending latch, sweep FSM, one-hot req_out.
// Ports: clk, rst, btn, cur_floor, door_open, firealarm -> req_out, pending, dir_up, busy
// Optional CALL_TIMEOUT_EN adds per-floor age counters and the call_stale output.
import elevator_pkg::*;

module elevator_call_scheduler #(
    parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
    parameter int FLOOR_W         = DEF_FLOOR_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  door_open,
    input  logic                  firealarm,
    output logic [NUM_FLOORS-1:0] req_out,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
`ifdef CALL_TIMEOUT_EN
    output logic                  call_stale,
`endif
    output logic                  busy
);

    state_t state;
    state_t state_n;

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] pend_n;
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] req_n;
    logic [NUM_FLOORS-1:0] stale_vec;

    logic [FLOOR_W-1:0] cf;
    logic [FLOOR_W-1:0] up_t;
    logic [FLOOR_W-1:0] dn_t;
    logic [FLOOR_W-1:0] du;
    logic [FLOOR_W-1:0] dd;
    logic [FLOOR_W-1:0] stale_f;
    logic [FLOOR_W-1:0] tgt_f;

    logic has_above;
    logic has_below;
    logic stale_hit;
    logic ovr;
    logic tgt_vld;

    genvar g;
    generate
        for (g = 0; g < NUM_FLOORS; g++) begin : g_btn
            call_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn[g]),
                .press(press[g])
            );
        end
    endgenerate

    // Out-of-range floor codes behave as the top floor.
    always_comb begin
        cf = cur_floor;
        if (int'(cur_floor) >= NUM_FLOORS)
            cf = FLOOR_W'(NUM_FLOORS - 1);
    end

    // Nearest pending floor on each side of the car.
    always_comb begin
        has_above = 1'b0;
        has_below = 1'b0;
        up_t      = cf;
        dn_t      = cf;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && i > int'(cf)) begin
                has_above = 1'b1;
                up_t      = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && i < int'(cf)) begin
                has_below = 1'b1;
                dn_t      = FLOOR_W'(i);
            end
        end
        du = up_t - cf;
        dd = cf - dn_t;
    end

`ifdef CALL_TIMEOUT_EN
    localparam int AW = $clog2(TIMEOUT_CYCLES + 1);

    logic [AW-1:0] age [NUM_FLOORS];

    // Ages clear on the same edge as their pending bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FLOORS; i++)
                age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (!pend_n[i])
                    age[i] <= '0;
                else if (age[i] != AW'(TIMEOUT_CYCLES))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stale_vec = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            stale_vec[i] = (age[i] == AW'(TIMEOUT_CYCLES));
    end

    assign call_stale = |stale_vec;
`else
    assign stale_vec = '0;
`endif

    // Lowest stale floor wins.
    always_comb begin
        stale_hit = 1'b0;
        stale_f   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (stale_vec[i]) begin
                stale_hit = 1'b1;
                stale_f   = FLOOR_W'(i);
            end
        end
    end

    assign ovr = stale_hit && (stale_f != cf) && !firealarm && (state != S_FIRE);

    always_comb begin
        state_n = state;
        if (firealarm) begin
            state_n = S_FIRE;
        end else begin
            unique case (state)
                S_FIRE: state_n = S_IDLE;
                S_UP:   state_n = has_above ? S_UP :
                                  (has_below ? S_DOWN : S_IDLE);
                S_DOWN: state_n = has_below ? S_DOWN :
                                  (has_above ? S_UP : S_IDLE);
                S_IDLE: begin
                    unique case (1'b1)
                        has_above && has_below:
                            state_n = (du <= dd) ? S_UP : S_DOWN;
                        has_above && !has_below:
                            state_n = S_UP;
                        !has_above && has_below:
                            state_n = S_DOWN;
                        default:
                            state_n = S_IDLE;
                    endcase
                end
            endcase
            if (ovr)
                state_n = (stale_f > cf) ? S_UP : S_DOWN;
        end
    end

    // Target follows the state being entered, so req_out moves with the state.
    always_comb begin
        tgt_vld = 1'b1;
        tgt_f   = FLOOR_W'(FLOOR_G);
        unique case (state_n)
            S_FIRE: tgt_f   = FLOOR_W'(FLOOR_G);
            S_UP:   tgt_f   = ovr ? stale_f : up_t;
            S_DOWN: tgt_f   = ovr ? stale_f : dn_t;
            S_IDLE: tgt_vld = 1'b0;
        endcase
        req_n = tgt_vld ? (NUM_FLOORS'(1) << tgt_f) : '0;
    end

    // Clear beats set; fire recall wipes and blocks new calls.
    always_comb begin
        clr    = door_open ? (NUM_FLOORS'(1) << cf) : '0;
        pend_n = (pending | press) & ~clr;
        if (firealarm || state == S_FIRE)
            pend_n = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pending <= '0;
            req_out <= '0;
        end else begin
            state   <= state_n;
            pending <= pend_n;
            req_out <= req_n;
        end
    end

    assign dir_up = (state == S_UP);
    assign busy   = (|pending) || (state == S_FIRE);

endmodule
